// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: one pipeline stage register with a valid/ready handshake,
// a 2-entry skid buffer, flush-to-bubble and a saturating stall counter.
//
// Handshake: an entry moves across an interface on a rising edge where both
// valid and ready are 1. in_ready depends only on registered state and reset,
// so there is never a combinational path from out_ready back to in_ready.
// A producer holding valid keeps its payload stable until it is accepted.
module pipe_stage_hs #(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 12,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  // State encoding is {main_valid, skid_valid}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_main_valid;
  logic                w_skid_valid;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_ld_main_in;
  logic                w_ld_main_skid;
  logic                w_ld_skid;
  logic                w_stall;

  assign w_main_valid = r_state[1];
  assign w_skid_valid = r_state[0];

  // Ready only while the skid slot is free; held low during reset.
  assign in_ready   = ~reset & ~w_skid_valid;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_main_valid & out_ready;
  assign w_stall    = w_main_valid & ~out_ready;

  assign out_valid  = w_main_valid;
  assign out_data   = r_main_data;
  assign out_ctrl   = w_main_valid ? r_main_ctrl : BUBBLE_CTRL;
  assign stall_cnt  = r_stall_cnt;
  assign dbg_state  = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and register-load strobes; flush empties the stage and
  // suppresses every load so a flushed or incoming entry goes nowhere.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_xfer) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_xfer) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt    = ST_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // Payload/control registers; main is refilled either from the input or
  // from the skid slot, which keeps strict arrival order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_ld_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  // Saturating count of cycles where a valid output is being held back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !flush && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
